// File: rtl/multicycle_core_pkg.sv
// Shared constants for multicycle_core: opcodes, instruction field positions
// and FSM state encoding.
package multicycle_core_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_BZ   = 4'h8;
   localparam logic [3:0] OP_JR   = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hA;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 10;
   localparam int RS1_HI = 9;
   localparam int RS1_LO = 8;
   localparam int RS2_HI = 7;
   localparam int RS2_LO = 6;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_MEM   = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

endpackage

// File: rtl/core_regfile.sv
// Four-entry register file: two combinational read ports, one write port.
// With MULTICYCLE_CORE_DEBUG_EN the whole file is also exposed on a flat bus.
module core_regfile #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [1:0]    waddr,
   input  logic [DW-1:0] wdata,
   input  logic [1:0]    raddr1,
   output logic [DW-1:0] rdata1,
   input  logic [1:0]    raddr2,
   output logic [DW-1:0] rdata2
`ifdef MULTICYCLE_CORE_DEBUG_EN
   ,
   output logic [4*DW-1:0] dump
`endif
);

   logic [DW-1:0] regs [4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Reads see the pre-write value when a write lands in the same cycle.
   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

`ifdef MULTICYCLE_CORE_DEBUG_EN
   for (genvar gi = 0; gi < 4; gi++) begin : g_dump
      assign dump[gi*DW +: DW] = regs[gi];
   end
`endif

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-ISA core with one shared req/ack memory port.
// Optional debug ports are enabled by defining MULTICYCLE_CORE_DEBUG_EN.
module multicycle_core
   import multicycle_core_pkg::*;
#(
   parameter int            DW       = 16,
   parameter logic [DW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          halted,
   output logic [DW-1:0] pc
`ifdef MULTICYCLE_CORE_DEBUG_EN
   ,
   output logic [DW-1:0] dbg_reg0,
   output logic [DW-1:0] dbg_reg1,
   output logic [DW-1:0] dbg_reg2,
   output logic [DW-1:0] dbg_reg3,
   output logic [15:0]   dbg_ir,
   output logic          dbg_retire
`endif
);

   localparam logic [DW-1:0] ONE = DW'(1);

   logic [1:0]    state_reg;
   logic [DW-1:0] pc_reg;
   logic [15:0]   ir_reg;
   logic          z_reg;

   logic [3:0]    op;
   logic [1:0]    rd_idx;
   logic [1:0]    rs1_idx;
   logic [1:0]    rs2_idx;
   logic [DW-1:0] imm_ext;
   logic [DW-1:0] rs1_val;
   logic [DW-1:0] rs2_val;
   logic [DW-1:0] pc_inc;
   logic [DW-1:0] alu_result;
   logic [DW-1:0] exec_pc_next;
   logic          is_alu;
   logic          xfer_done;
   logic          rf_we;
   logic [DW-1:0] rf_wdata;

   assign op      = ir_reg[OP_HI:OP_LO];
   assign rd_idx  = ir_reg[RD_HI:RD_LO];
   assign rs1_idx = ir_reg[RS1_HI:RS1_LO];
   assign rs2_idx = ir_reg[RS2_HI:RS2_LO];
   assign imm_ext = {{(DW-8){ir_reg[IMM_HI]}}, ir_reg[IMM_HI:IMM_LO]};
   assign pc_inc  = pc_reg + ONE;
   assign is_alu  = (op <= OP_XOR);

   assign xfer_done = mem_req && mem_ack;
   assign halted    = (state_reg == S_HALT);
   assign pc        = pc_reg;

   always_comb begin
      alu_result = '0;
      case (op)
         OP_ADD:  alu_result = rs1_val + rs2_val;
         OP_SUB:  alu_result = rs1_val - rs2_val;
         OP_AND:  alu_result = rs1_val & rs2_val;
         OP_OR:   alu_result = rs1_val | rs2_val;
         OP_XOR:  alu_result = rs1_val ^ rs2_val;
         default: alu_result = '0;
      endcase
   end

   // Next PC for instructions that finish in EXEC; Z is the value from
   // before this instruction since only ALU ops write it.
   always_comb begin
      exec_pc_next = pc_inc;
      case (op)
         OP_BZ:   exec_pc_next = z_reg ? (pc_reg + imm_ext) : pc_inc;
         OP_JR:   exec_pc_next = rs1_val;
         default: exec_pc_next = pc_inc;
      endcase
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_wdata = alu_result;
      if (state_reg == S_EXEC && (is_alu || op == OP_LDI)) begin
         rf_we    = 1'b1;
         rf_wdata = (op == OP_LDI) ? imm_ext : alu_result;
      end else if (state_reg == S_MEM && xfer_done && op == OP_LD) begin
         rf_we    = 1'b1;
         rf_wdata = mem_rdata;
      end
   end

   core_regfile #(
      .DW(DW)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (rf_we),
      .waddr  (rd_idx),
      .wdata  (rf_wdata),
      .raddr1 (rs1_idx),
      .rdata1 (rs1_val),
      .raddr2 (rs2_idx),
      .rdata2 (rs2_val)
`ifdef MULTICYCLE_CORE_DEBUG_EN
      ,
      .dump   ({dbg_reg3, dbg_reg2, dbg_reg1, dbg_reg0})
`endif
   );

   // Requests are raised on the state transition, so a zero-wait fetch
   // completes in the first FETCH cycle (except the one just after reset).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_FETCH;
         pc_reg    <= RESET_PC;
         ir_reg    <= '0;
         z_reg     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc_reg;
               end else if (mem_ack) begin
                  ir_reg    <= mem_rdata[15:0];
                  mem_req   <= 1'b0;
                  state_reg <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_LD, OP_ST: begin
                     mem_req  <= 1'b1;
                     mem_we   <= (op == OP_ST);
                     mem_addr <= rs1_val;
                     if (op == OP_ST) mem_wdata <= rs2_val;
                     state_reg <= S_MEM;
                  end
                  OP_HALT: begin
                     state_reg <= S_HALT;
                  end
                  default: begin
                     if (is_alu) z_reg <= (alu_result == '0);
                     pc_reg    <= exec_pc_next;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= exec_pc_next;
                     state_reg <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (xfer_done) begin
                  pc_reg    <= pc_inc;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= pc_inc;
                  state_reg <= S_FETCH;
               end
            end
            default: begin
               mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef MULTICYCLE_CORE_DEBUG_EN
   assign dbg_ir     = ir_reg;
   assign dbg_retire = (state_reg == S_EXEC && op != OP_LD && op != OP_ST) ||
                       (state_reg == S_MEM && xfer_done);
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: directed programs push expected memory
// transactions; a negedge monitor pops and compares each completed transfer.
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        halted;
   logic [15:0] pc;
`ifdef MULTICYCLE_CORE_DEBUG_EN
   logic [15:0] dbg_reg0, dbg_reg1, dbg_reg2, dbg_reg3, dbg_ir;
   logic        dbg_retire;
`endif

   multicycle_core #(.DW(16), .RESET_PC(16'h0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .halted    (halted),
      .pc        (pc)
`ifdef MULTICYCLE_CORE_DEBUG_EN
      ,
      .dbg_reg0  (dbg_reg0),
      .dbg_reg1  (dbg_reg1),
      .dbg_reg2  (dbg_reg2),
      .dbg_reg3  (dbg_reg3),
      .dbg_ir    (dbg_ir),
      .dbg_retire(dbg_retire)
`endif
   );

   always #5 clk = ~clk;

   // Memory model with a configurable number of wait states per transfer.
   logic [15:0] mem [0:65535];
   int wait_states = 0;
   int wait_cnt;

   assign mem_ack   = mem_req && (wait_cnt >= wait_states);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt = 0;
      end else if (mem_req && mem_ack) begin
         wait_cnt = 0;
         if (mem_we) mem[mem_addr] = mem_wdata;
      end else if (mem_req) begin
         wait_cnt = wait_cnt + 1;
      end
   end

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;

   txn_t exp_q[$];
   int checks   = 0;
   int failures = 0;
   int wr40_count   = 0;
   int retire_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      txn_t t;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      exp_q.push_back(t);
   endtask

   // Monitor: compares completed transfers and checks request holding.
   logic        prev_stall = 1'b0;
   logic        prev_we;
   logic [15:0] prev_addr;
   logic [15:0] prev_wdata;

   always @(negedge clk) begin
      txn_t t;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_req", 32'(mem_req), 32'(1'b1));
            check("hold_addr", 32'(mem_addr), 32'(prev_addr));
            check("hold_we", 32'(mem_we), 32'(prev_we));
            if (prev_we) check("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
         end
`ifdef MULTICYCLE_CORE_DEBUG_EN
         if (dbg_retire) retire_count++;
`endif
         if (mem_req && mem_ack) begin
            $display("txn we=%0b addr=%h wdata=%h rdata=%h", mem_we, mem_addr, mem_wdata, mem_rdata);
            if (mem_we && mem_addr == 16'h0040) wr40_count++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_txn actual=addr %h required=no transfer", mem_addr);
            end else begin
               t = exp_q.pop_front();
               check("txn_we", 32'(mem_we), 32'(t.we));
               check("txn_addr", 32'(mem_addr), 32'(t.addr));
               if (t.we) check("txn_wdata", 32'(mem_wdata), 32'(t.wdata));
            end
         end
         prev_stall = mem_req && !mem_ack;
         prev_we    = mem_we;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      exp_q.delete();
   endtask

   // LDI r1,5; LDI r2,-3; ADD r3,r1,r2; HALT
   task automatic load_prog_a();
      clear_mem();
      mem[0] = 16'h5405;
      mem[1] = 16'h58FD;
      mem[2] = 16'h0D80;
      mem[3] = 16'hA000;
      for (int a = 0; a < 4; a++) push_txn(1'b0, 16'(a), 16'h0000);
   endtask

   // LDI r1,0x40; LDI r2,0x7F; ST r2,[r1]; LD r0,[r1]; ST r0,[r2]; HALT
   task automatic load_prog_b();
      clear_mem();
      mem[0] = 16'h5440;
      mem[1] = 16'h587F;
      mem[2] = 16'h7180;
      mem[3] = 16'h6100;
      mem[4] = 16'h7200;
      mem[5] = 16'hA000;
      push_txn(1'b0, 16'h0000, 16'h0000);
      push_txn(1'b0, 16'h0001, 16'h0000);
      push_txn(1'b0, 16'h0002, 16'h0000);
      push_txn(1'b1, 16'h0040, 16'h007F);
      push_txn(1'b0, 16'h0003, 16'h0000);
      push_txn(1'b0, 16'h0040, 16'h0000);
      push_txn(1'b0, 16'h0004, 16'h0000);
      push_txn(1'b1, 16'h007F, 16'h007F);
      push_txn(1'b0, 16'h0005, 16'h0000);
   endtask

   // Branch loop, JR to 0xFFFF and PC wrap back to 0 where a taken BZ halts.
   task automatic load_prog_c();
      logic [15:0] fetches [14];
      clear_mem();
      mem[0]      = 16'h8008;   // BZ +8 (Z=0 first time: falls through)
      mem[1]      = 16'h54FF;   // LDI r1,-1
      mem[2]      = 16'h5801;   // LDI r2,1
      mem[3]      = 16'h0A40;   // ADD r2,r2,r1
      mem[4]      = 16'hB000;   // NOP
      mem[5]      = 16'h80FE;   // BZ -2
      mem[6]      = 16'h1140;   // SUB r0,r1,r1 -> Z=1
      mem[7]      = 16'h9100;   // JR r1
      mem[8]      = 16'hA000;   // HALT
      mem[16'hFFFF] = 16'hB000; // NOP, wraps to 0
      fetches = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h3, 16'h4,
                  16'h5, 16'h6, 16'h7, 16'hFFFF, 16'h0, 16'h8};
      for (int i = 0; i < 14; i++) push_txn(1'b0, fetches[i], 16'h0000);
   endtask

   task automatic run_prog(input int ws, input int budget, output int cycles);
      @(negedge clk);
      rst = 1'b1;
      wait_states = ws;
      retire_count = 0;
      @(negedge clk);
      rst = 1'b0;
      cycles = 0;
      while (!halted && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!halted) begin
         checks++;
         failures++;
         $display("FAIL halt_timeout actual=running required=halted within %0d cycles", budget);
      end
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cyc;
      bit found;

      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);

      // Program A, zero wait: halted 8 cycles after the first request.
      load_prog_a();
      run_prog(0, 100, cyc);
      check("a0_cycles", 32'(cyc), 32'd9);
      check("a0_pc", 32'(pc), 32'h3);
      check("a0_r3", 32'(dut.u_regfile.regs[3]), 32'h2);
      check("a0_z", 32'(dut.z_reg), 32'd0);
      check("a0_req_off", 32'(mem_req), 32'd0);
`ifdef MULTICYCLE_CORE_DEBUG_EN
      check("a0_retire", 32'(retire_count), 32'd4);
      check("a0_dbg_reg3", 32'(dbg_reg3), 32'h2);
`endif

      // Program A, two wait states per transfer.
      load_prog_a();
      run_prog(2, 200, cyc);
      check("a2_cycles", 32'(cyc), 32'd17);
      check("a2_pc", 32'(pc), 32'h3);
      check("a2_r3", 32'(dut.u_regfile.regs[3]), 32'h2);
      check("a2_z", 32'(dut.z_reg), 32'd0);

      // Program B: store then load back through memory.
      load_prog_b();
      wr40_count = 0;
      run_prog(0, 200, cyc);
      check("b_cycles", 32'(cyc), 32'd16);
      check("b_pc", 32'(pc), 32'h5);
      check("b_mem40", 32'(mem[16'h0040]), 32'h007F);
      check("b_mem7f", 32'(mem[16'h007F]), 32'h007F);
      check("b_r0", 32'(dut.u_regfile.regs[0]), 32'h007F);
      check("b_wr40_count", 32'(wr40_count), 32'd1);

      // Program C: BZ taken/not taken, JR, PC wrap.
      load_prog_c();
      run_prog(1, 400, cyc);
      check("c_pc", 32'(pc), 32'h8);
      check("c_r1", 32'(dut.u_regfile.regs[1]), 32'hFFFF);
      check("c_r2", 32'(dut.u_regfile.regs[2]), 32'hFFFF);
      check("c_z", 32'(dut.z_reg), 32'd1);

      // Reset while a store waits for ack in MEM.
      load_prog_b();
      @(negedge clk);
      rst = 1'b1;
      wait_states = 5;
      @(negedge clk);
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_we) found = 1'b1;
      end
      if (!found) begin
         checks++;
         failures++;
         $display("FAIL mid_store_seen actual=none required=store request");
      end
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_req", 32'(mem_req), 32'd0);
      check("mid_rst_pc", 32'(pc), 32'd0);
      check("mid_rst_r1", 32'(dut.u_regfile.regs[1]), 32'd0);
      check("mid_rst_r2", 32'(dut.u_regfile.regs[2]), 32'd0);
      check("mid_rst_mem40", 32'(mem[16'h0040]), 32'd0);
      exp_q.delete();

      // After release the core restarts cleanly from RESET_PC.
      load_prog_a();
      run_prog(0, 100, cyc);
      check("post_rst_cycles", 32'(cyc), 32'd9);
      check("post_rst_r3", 32'(dut.u_regfile.regs[3]), 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=still running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
